// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : minisrc_pkg
// Purpose  : Shared opcodes, ALU/MY codes, sequencer state type and decode
//            helpers for the MiniSRC control path.
// Revision : 1.0  initial release
// ============================================================================
package minisrc_pkg;

    localparam logic [4:0] c_OP_LD   = 5'b00000;
    localparam logic [4:0] c_OP_ST   = 5'b00010;
    localparam logic [4:0] c_OP_ADD  = 5'b00011;
    localparam logic [4:0] c_OP_SUB  = 5'b00100;
    localparam logic [4:0] c_OP_AND  = 5'b00101;
    localparam logic [4:0] c_OP_OR   = 5'b00110;
    localparam logic [4:0] c_OP_ADDI = 5'b01100;
    localparam logic [4:0] c_OP_MUL  = 5'b01111;
    localparam logic [4:0] c_OP_DIV  = 5'b10000;
    localparam logic [4:0] c_OP_NOP  = 5'b11010;
    localparam logic [4:0] c_OP_HALT = 5'b11011;

    localparam logic [3:0] c_ALU_ADD = 4'b0000;
    localparam logic [3:0] c_ALU_SUB = 4'b0001;
    localparam logic [3:0] c_ALU_OR  = 4'b0010;
    localparam logic [3:0] c_ALU_AND = 4'b0011;
    localparam logic [3:0] c_ALU_DIV = 4'b0100;
    localparam logic [3:0] c_ALU_MUL = 4'b0101;

    localparam logic [1:0] c_MY_RZ1 = 2'd0;
    localparam logic [1:0] c_MY_RZ0 = 2'd1;
    localparam logic [1:0] c_MY_MEM = 2'd2;
    localparam logic [1:0] c_MY_RET = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_LOADY  = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    function automatic logic is_legal(input logic [4:0] op);
        case (op)
            c_OP_LD, c_OP_ST, c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR,
            c_OP_ADDI, c_OP_MUL, c_OP_DIV, c_OP_NOP, c_OP_HALT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Memory and immediate forms all compute their operand/address with add.
    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            c_OP_SUB: return c_ALU_SUB;
            c_OP_OR:  return c_ALU_OR;
            c_OP_AND: return c_ALU_AND;
            c_OP_DIV: return c_ALU_DIV;
            c_OP_MUL: return c_ALU_MUL;
            default:  return c_ALU_ADD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer_if
// Purpose  : Datapath control bundle between the sequencer and the datapath.
// Revision : 1.0  initial release
// ============================================================================
interface control_sequencer_if;
    logic [31:0] iIR;
    logic        iImemValid;
    logic        iDmemAck;
    logic        oIrEn, oPcEn, oRaEn, oRbEn, oRz0En, oRz1En, oRmEn, oRyEn;
    logic        oRfWe;
    logic        oMbSel;
    logic [1:0]  oMySel;
    logic [3:0]  oAluCtrl;
    logic        oDmemReq, oDmemWe;
    logic        oHalted;
    logic        oIllegal;

    modport master (
        input  iIR, iImemValid, iDmemAck,
        output oIrEn, oPcEn, oRaEn, oRbEn, oRz0En, oRz1En, oRmEn, oRyEn,
               oRfWe, oMbSel, oMySel, oAluCtrl, oDmemReq, oDmemWe,
               oHalted, oIllegal
    );

    modport slave (
        output iIR, iImemValid, iDmemAck,
        input  oIrEn, oPcEn, oRaEn, oRbEn, oRz0En, oRz1En, oRmEn, oRyEn,
               oRfWe, oMbSel, oMySel, oAluCtrl, oDmemReq, oDmemWe,
               oHalted, oIllegal
    );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Purpose  : Multicycle MiniSRC control unit; one instruction at a time with
//            instruction/data memory wait states and a multicycle divide.
// Revision : 1.0  initial release
// ============================================================================
module control_sequencer
    import minisrc_pkg::*;
#(
    parameter int DIV_LAT = 32
) (
    input  wire logic            iClk,
    input  wire logic            nRst,
    control_sequencer_if.master  bus
);

    localparam logic [7:0] c_DIV_LOAD = DIV_LAT[7:0];

    state_t     r_state;
    logic [4:0] r_op;
    logic [7:0] r_div_cnt;

    logic [4:0] w_ir_op;
    logic       w_unused_ir;
    logic       w_is_mem;

    assign w_ir_op     = bus.iIR[31:27];
    assign w_unused_ir = ^bus.iIR[26:0];
    assign w_is_mem    = (r_op == c_OP_LD) || (r_op == c_OP_ST);

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_state   <= S_IDLE;
            r_op      <= 5'd0;
            r_div_cnt <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= S_FETCH;
                S_FETCH: if (bus.iImemValid) r_state <= S_DECODE;
                S_DECODE: begin
                    r_op <= w_ir_op;
                    if (w_ir_op == c_OP_HALT) begin
                        r_state <= S_HALT;
                    end else if (w_ir_op == c_OP_NOP || !is_legal(w_ir_op)) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state   <= S_EXEC;
                        // Non-divide ops spend exactly one cycle in EXEC.
                        r_div_cnt <= (w_ir_op == c_OP_DIV) ? c_DIV_LOAD : 8'd1;
                    end
                end
                S_EXEC: begin
                    if (r_div_cnt > 8'd1) begin
                        r_div_cnt <= r_div_cnt - 8'd1;
                    end else begin
                        r_state <= w_is_mem ? S_MEM : S_LOADY;
                    end
                end
                S_MEM: begin
                    if (bus.iDmemAck) begin
                        r_state <= (r_op == c_OP_LD) ? S_WB : S_FETCH;
                    end
                end
                S_LOADY: r_state <= S_WB;
                S_WB:    r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.oIrEn    = 1'b0;
        bus.oPcEn    = 1'b0;
        bus.oRaEn    = 1'b0;
        bus.oRbEn    = 1'b0;
        bus.oRz0En   = 1'b0;
        bus.oRz1En   = 1'b0;
        bus.oRmEn    = 1'b0;
        bus.oRyEn    = 1'b0;
        bus.oRfWe    = 1'b0;
        bus.oMbSel   = 1'b0;
        bus.oMySel   = c_MY_RZ1;
        bus.oAluCtrl = c_ALU_ADD;
        bus.oDmemReq = 1'b0;
        bus.oDmemWe  = 1'b0;
        bus.oHalted  = 1'b0;
        bus.oIllegal = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.oIrEn = bus.iImemValid;
                bus.oPcEn = bus.iImemValid;
            end
            S_DECODE: begin
                bus.oRaEn    = 1'b1;
                bus.oRbEn    = 1'b1;
                bus.oIllegal = !is_legal(w_ir_op);
            end
            S_EXEC: begin
                bus.oAluCtrl = alu_code(r_op);
                bus.oMbSel   = w_is_mem || (r_op == c_OP_ADDI);
                if (r_div_cnt == 8'd1) begin
                    bus.oRz0En = 1'b1;
                    bus.oRz1En = (r_op == c_OP_MUL) || (r_op == c_OP_DIV);
                    bus.oRmEn  = (r_op == c_OP_ST);
                end
            end
            S_MEM: begin
                bus.oDmemReq = 1'b1;
                bus.oDmemWe  = (r_op == c_OP_ST);
                if (bus.iDmemAck && r_op == c_OP_LD) begin
                    bus.oRyEn  = 1'b1;
                    bus.oMySel = c_MY_MEM;
                end
            end
            S_LOADY: begin
                bus.oRyEn  = 1'b1;
                bus.oMySel = c_MY_RZ0;
            end
            S_WB:    bus.oRfWe   = 1'b1;
            S_HALT:  bus.oHalted = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Purpose  : Self-checking bench: directed vector table, reset/halt sequences
//            and randomized instruction streams against a cycle-trace model.
// Revision : 1.0  initial release
// ============================================================================
module tb_control_sequencer;

    localparam int DIV_LAT = 4;

    localparam logic [4:0] OP_LD = 5'b00000, OP_ST = 5'b00010, OP_ADD = 5'b00011,
                           OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110,
                           OP_ADDI = 5'b01100, OP_MUL = 5'b01111, OP_DIV = 5'b10000,
                           OP_NOP = 5'b11010, OP_HALT = 5'b11011;

    localparam logic [19:0] E_IR = 20'h80000, E_PC = 20'h40000, E_RA = 20'h20000,
                            E_RB = 20'h10000, E_RZ0 = 20'h08000, E_RZ1 = 20'h04000,
                            E_RM = 20'h02000, E_RY = 20'h01000, E_RF = 20'h00800,
                            E_MB = 20'h00400, E_REQ = 20'h00008, E_DWE = 20'h00004,
                            E_HLT = 20'h00002, E_ILL = 20'h00001;

    typedef struct packed {
        logic [31:0] ir;
        logic        v;
        logic        ack;
        logic [19:0] exp;
    } vec_t;

    logic clk;
    logic nRst;
    int   tests;
    int   fails;
    vec_t dt[$];
    vec_t vq[$];
    logic [4:0] ops[11];

    control_sequencer_if bus();

    control_sequencer #(.DIV_LAT(DIV_LAT)) dut (
        .iClk (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    wire logic [19:0] outs = {bus.oIrEn, bus.oPcEn, bus.oRaEn, bus.oRbEn, bus.oRz0En,
                              bus.oRz1En, bus.oRmEn, bus.oRyEn, bus.oRfWe, bus.oMbSel,
                              bus.oMySel, bus.oAluCtrl, bus.oDmemReq, bus.oDmemWe,
                              bus.oHalted, bus.oIllegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] my(input int n);
        return 20'(n) << 8;
    endfunction

    function automatic logic [19:0] alu(input int n);
        return 20'(n) << 4;
    endfunction

    function automatic vec_t mk(input logic [31:0] ir, input logic v, input logic ack,
                                input logic [19:0] exp);
        vec_t r;
        r.ir = ir; r.v = v; r.ack = ack; r.exp = exp;
        return r;
    endfunction

    function automatic bit legal(input logic [4:0] op);
        foreach (ops[i]) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %05h expected %05h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; drives inputs, checks mid-cycle, leaves at posedge+1.
    task automatic apply(input vec_t v, input string name);
        bus.iIR        = v.ir;
        bus.iImemValid = v.v;
        bus.iDmemAck   = v.ack;
        @(negedge clk);
        check(name, outs, v.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        bus.iImemValid = 1'b0;
        bus.iDmemAck   = 1'b0;
        #1 check("reset_outputs", outs, 20'h0);
        @(posedge clk);
        #1 nRst = 1'b1;
        apply(mk(32'h0, 1'b1, 1'b1, 20'h0), "idle");
    endtask

    // Expected per-cycle trace of one instruction, derived from the
    // instruction-level behaviour: FETCH waits, DECODE, EXEC, MEM, LOADY, WB.
    function automatic void model(input logic [31:0] ir, input int wi, input int wd);
        logic [4:0]  op = ir[31:27];
        bit          is_ld = (op == OP_LD), is_st = (op == OP_ST);
        bit          md = (op == OP_MUL) || (op == OP_DIV);
        logic [19:0] ex, mem;
        int          n, code;
        for (int i = 0; i < wi; i++) vq.push_back(mk($urandom, 1'b0, 1'($urandom), 20'h0));
        vq.push_back(mk(ir, 1'b1, 1'($urandom), E_IR | E_PC));
        vq.push_back(mk(ir, 1'($urandom), 1'($urandom), E_RA | E_RB | (legal(op) ? 20'h0 : E_ILL)));
        if (!legal(op) || op == OP_NOP) return;
        if (op == OP_HALT) begin
            for (int i = 0; i < 4; i++) vq.push_back(mk($urandom, 1'($urandom), 1'($urandom), E_HLT));
            return;
        end
        case (op)
            OP_SUB: code = 1;  OP_OR: code = 2;  OP_AND: code = 3;
            OP_DIV: code = 4;  OP_MUL: code = 5; default: code = 0;
        endcase
        n = (op == OP_DIV) ? DIV_LAT : 1;
        ex = alu(code) | ((is_ld || is_st || op == OP_ADDI) ? E_MB : 20'h0);
        for (int k = 0; k < n; k++)
            vq.push_back(mk($urandom, 1'($urandom), 1'($urandom),
                            ex | ((k == n - 1) ? (E_RZ0 | (md ? E_RZ1 : 20'h0) | (is_st ? E_RM : 20'h0)) : 20'h0)));
        if (is_ld || is_st) begin
            mem = E_REQ | (is_st ? E_DWE : 20'h0);
            for (int i = 0; i < wd; i++) vq.push_back(mk($urandom, 1'($urandom), 1'b0, mem));
            vq.push_back(mk($urandom, 1'($urandom), 1'b1, mem | (is_ld ? (E_RY | my(2)) : 20'h0)));
            if (is_st) return;
        end else begin
            vq.push_back(mk($urandom, 1'($urandom), 1'($urandom), E_RY | my(1)));
        end
        vq.push_back(mk($urandom, 1'($urandom), 1'($urandom), E_RF));
    endfunction

    initial begin
        ops = '{OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_MUL, OP_DIV, OP_NOP, OP_HALT};
        tests = 0;
        fails = 0;
        nRst  = 1'b0;
        bus.iIR = 32'h0;
        bus.iImemValid = 1'b0;
        bus.iDmemAck   = 1'b0;

        // ADD, NOP, illegal, stalled ST, LD with 3-cycle MEM, DIV; EXEC-time iIR set to HALT.
        dt.push_back(mk(32'h18000000, 1, 0, E_IR | E_PC));
        dt.push_back(mk(32'h18000000, 0, 0, E_RA | E_RB));
        dt.push_back(mk(32'hD8000000, 1, 1, E_RZ0));
        dt.push_back(mk(32'hD8000000, 0, 0, E_RY | my(1)));
        dt.push_back(mk(32'hD8000000, 1, 0, E_RF));
        dt.push_back(mk(32'hD0000000, 1, 0, E_IR | E_PC));
        dt.push_back(mk(32'hD0000000, 1, 0, E_RA | E_RB));
        dt.push_back(mk(32'hF8000000, 1, 0, E_IR | E_PC));
        dt.push_back(mk(32'hF8000000, 1, 0, E_RA | E_RB | E_ILL));
        dt.push_back(mk(32'h10000000, 0, 1, 20'h0));
        dt.push_back(mk(32'h10000000, 1, 0, E_IR | E_PC));
        dt.push_back(mk(32'h10000000, 0, 1, E_RA | E_RB));
        dt.push_back(mk(32'hD8000000, 0, 1, E_RZ0 | E_RM | E_MB));
        dt.push_back(mk(32'hD8000000, 0, 1, E_REQ | E_DWE));
        dt.push_back(mk(32'h00000000, 1, 0, E_IR | E_PC));
        dt.push_back(mk(32'h00000000, 0, 0, E_RA | E_RB));
        dt.push_back(mk(32'h00000000, 0, 0, E_RZ0 | E_MB));
        dt.push_back(mk(32'h00000000, 0, 0, E_REQ));
        dt.push_back(mk(32'h00000000, 0, 0, E_REQ));
        dt.push_back(mk(32'h00000000, 0, 1, E_REQ | E_RY | my(2)));
        dt.push_back(mk(32'h00000000, 0, 1, E_RF));
        dt.push_back(mk(32'h80000000, 1, 0, E_IR | E_PC));
        dt.push_back(mk(32'h80000000, 0, 0, E_RA | E_RB));
        dt.push_back(mk(32'h18000000, 1, 1, alu(4)));
        dt.push_back(mk(32'h18000000, 1, 1, alu(4)));
        dt.push_back(mk(32'h18000000, 1, 1, alu(4)));
        dt.push_back(mk(32'h18000000, 1, 1, alu(4) | E_RZ0 | E_RZ1));
        dt.push_back(mk(32'h18000000, 1, 0, E_RY | my(1)));
        dt.push_back(mk(32'h18000000, 1, 0, E_RF));
        dt.push_back(mk(32'h18000000, 0, 0, 20'h0));

        do_reset();
        foreach (dt[i]) apply(dt[i], $sformatf("dir[%0d]", i));

        // Reset asserted in the second DIV EXEC cycle.
        do_reset();
        apply(mk(32'h80000000, 1, 0, E_IR | E_PC), "div_fetch");
        apply(mk(32'h80000000, 0, 0, E_RA | E_RB), "div_decode");
        apply(mk(32'h80000000, 0, 0, alu(4)), "div_exec1");
        #2 nRst = 1'b0;
        #1 check("rst_mid_div", outs, 20'h0);
        @(posedge clk);
        #1 nRst = 1'b1;
        apply(mk(32'h18000000, 1, 1, 20'h0), "div_rst_idle");
        apply(mk(32'h18000000, 1, 0, E_IR | E_PC), "div_rst_fetch");

        // Reset asserted while a load waits in MEM.
        do_reset();
        apply(mk(32'h00000000, 1, 0, E_IR | E_PC), "ld_fetch");
        apply(mk(32'h00000000, 0, 0, E_RA | E_RB), "ld_decode");
        apply(mk(32'h00000000, 0, 0, E_RZ0 | E_MB), "ld_exec");
        apply(mk(32'h00000000, 0, 0, E_REQ), "ld_mem");
        do_reset();
        apply(mk(32'h00000000, 0, 1, 20'h0), "ld_rst_fetch_idle");

        // HALT absorbs while iImemValid toggles.
        do_reset();
        apply(mk(32'hD8000000, 1, 0, E_IR | E_PC), "halt_fetch");
        apply(mk(32'hD8000000, 1, 0, E_RA | E_RB), "halt_decode");
        for (int i = 0; i < 8; i++) apply(mk(32'h18000000, 1'(i), 1'(i >> 1), E_HLT), "halt_hold");
        do_reset();

        // Random instruction streams against the trace model.
        for (int n = 0; n < 300; n++) begin
            int          sel = $urandom_range(0, 12);
            logic [4:0]  op;
            if (sel < 11) op = ops[sel];
            else begin
                op = 5'($urandom);
                while (legal(op)) op = 5'($urandom);
            end
            vq.delete();
            model({op, 27'($urandom)}, $urandom_range(0, 2), $urandom_range(0, 3));
            foreach (vq[i]) apply(vq[i], $sformatf("rnd%0d_op%02h_c%0d", n, op, i));
            if (op == OP_HALT) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
